// File: rtl/bmp_slave_feeder_if.sv
// Byte-stream input and packed-word output handshakes of the BMP slave feeder.
// The feeder takes the slave modport; the byte source and arbiter side take master.
interface bmp_slave_feeder_if #(
    parameter int DATA_BUS_SIZE = 32
);
    logic [7:0]               byte_in;
    logic                     byte_vld;
    logic                     byte_rdy;
    logic [DATA_BUS_SIZE-1:0] slv_data;
    logic                     slv_data_valid;
    logic                     slv_ready;

    modport master (
        output byte_in, byte_vld, slv_ready,
        input  byte_rdy, slv_data, slv_data_valid
    );

    modport slave (
        input  byte_in, byte_vld, slv_ready,
        output byte_rdy, slv_data, slv_data_valid
    );
endinterface

// File: rtl/bmp_slave_feeder.sv
// Parses and checks a BMP header arriving as a byte stream, skips to the pixel offset and
// packs pixel bytes little-endian into DATA_BUS_SIZE words for one arbiter slave port.
module bmp_slave_feeder #(
    parameter int  DATA_BUS_SIZE = 32,
    parameter int  HDR_LEN       = 54,
    parameter int  CNT_W         = 32,
    localparam int BPW           = DATA_BUS_SIZE / 8,
    localparam int PAD_W         = (BPW > 1) ? $clog2(BPW) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [1:0]          cfg_mode,
    input  logic [7:0]          cfg_data_proc,
    bmp_slave_feeder_if.slave   bus,
    output logic [1:0]          slv_mode,
    output logic [7:0]          slv_data_proc,
    output logic [PAD_W-1:0]    pad_bytes,
    output logic [CNT_W-1:0]    img_width,
    output logic [CNT_W-1:0]    img_height,
    output logic                busy,
    output logic                done,
    output logic                hdr_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_SKIP, S_PIXEL, S_DONE, S_ERR
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0]         file_size_q, file_size_d;
    logic [CNT_W-1:0]         pix_off_q, pix_off_d;
    logic [CNT_W-1:0]         width_q, width_d;
    logic [CNT_W-1:0]         height_q, height_d;
    logic [15:0]              bpp_q, bpp_d;
    logic                     magic_ok_q, magic_ok_d;
    logic [1:0]               mode_q, mode_d;
    logic [7:0]               proc_q, proc_d;
    logic [DATA_BUS_SIZE-1:0] pack_q, pack_d;
    logic [PAD_W-1:0]         lane_q, lane_d;
    logic                     valid_q, valid_d;
    logic                     last_q, last_d;
    logic [PAD_W-1:0]         pad_q, pad_d;
    logic                     done_q, done_d;
    logic                     hdr_err_q, hdr_err_d;

    logic byte_take;
    logic word_take;
    logic hdr_ok;
    logic is_last_byte;

    assign byte_take    = bus.byte_vld && bus.byte_rdy;
    assign word_take    = valid_q && bus.slv_ready;
    assign is_last_byte = (byte_cnt_q == file_size_q - CNT_W'(1));
    // Header fields are all captured well before the final header byte, so the
    // check can use the registered values on that byte.
    assign hdr_ok = magic_ok_q && (bpp_q == 16'd24) &&
                    (pix_off_q >= CNT_W'(HDR_LEN)) && (file_size_q > pix_off_q);

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        file_size_d = file_size_q;
        pix_off_d   = pix_off_q;
        width_d     = width_q;
        height_d    = height_q;
        bpp_d       = bpp_q;
        magic_ok_d  = magic_ok_q;
        mode_d      = mode_q;
        proc_d      = proc_q;
        pack_d      = pack_q;
        lane_d      = lane_q;
        valid_d     = valid_q;
        last_d      = last_q;
        pad_d       = pad_q;
        done_d      = 1'b0;
        hdr_err_d   = hdr_err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_HDR;
                    mode_d     = cfg_mode;
                    proc_d     = cfg_data_proc;
                    hdr_err_d  = 1'b0;
                    byte_cnt_d = '0;
                    pack_d     = '0;
                    lane_d     = '0;
                    valid_d    = 1'b0;
                    last_d     = 1'b0;
                    pad_d      = '0;
                end
            end
            S_HDR: begin
                if (byte_take) begin
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    for (int k = 0; k < 4; k++) begin
                        if (byte_cnt_q == CNT_W'(2 + k))  file_size_d[8*k +: 8] = bus.byte_in;
                        if (byte_cnt_q == CNT_W'(10 + k)) pix_off_d[8*k +: 8]   = bus.byte_in;
                        if (byte_cnt_q == CNT_W'(18 + k)) width_d[8*k +: 8]     = bus.byte_in;
                        if (byte_cnt_q == CNT_W'(22 + k)) height_d[8*k +: 8]    = bus.byte_in;
                    end
                    for (int k = 0; k < 2; k++) begin
                        if (byte_cnt_q == CNT_W'(28 + k)) bpp_d[8*k +: 8] = bus.byte_in;
                    end
                    if (byte_cnt_q == CNT_W'(0)) magic_ok_d = (bus.byte_in == 8'h42);
                    if (byte_cnt_q == CNT_W'(1)) magic_ok_d = magic_ok_q && (bus.byte_in == 8'h4D);
                    if (byte_cnt_q == CNT_W'(HDR_LEN - 1)) begin
                        if (!hdr_ok) begin
                            state_d   = S_ERR;
                            hdr_err_d = 1'b1;
                        end else if (pix_off_q == CNT_W'(HDR_LEN)) begin
                            state_d = S_PIXEL;
                        end else begin
                            state_d = S_SKIP;
                        end
                    end
                end
            end
            S_SKIP: begin
                if (byte_take) begin
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    if (byte_cnt_q == pix_off_q - CNT_W'(1)) state_d = S_PIXEL;
                end
            end
            S_PIXEL: begin
                // byte_rdy is low while a word is pending, so the two handshakes never coincide.
                if (word_take) begin
                    valid_d = 1'b0;
                    pack_d  = '0;
                    if (last_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end else if (byte_take) begin
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    for (int k = 0; k < BPW; k++) begin
                        if (lane_q == PAD_W'(k)) pack_d[8*k +: 8] = bus.byte_in;
                    end
                    if (is_last_byte || (lane_q == PAD_W'(BPW - 1))) begin
                        valid_d = 1'b1;
                        lane_d  = '0;
                        last_d  = is_last_byte;
                        if (is_last_byte) pad_d = PAD_W'(BPW - 1) - lane_q;
                    end else begin
                        lane_d = lane_q + PAD_W'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            byte_cnt_q  <= '0;
            file_size_q <= '0;
            pix_off_q   <= '0;
            width_q     <= '0;
            height_q    <= '0;
            bpp_q       <= '0;
            magic_ok_q  <= 1'b0;
            mode_q      <= '0;
            proc_q      <= '0;
            pack_q      <= '0;
            lane_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            pad_q       <= '0;
            done_q      <= 1'b0;
            hdr_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            file_size_q <= file_size_d;
            pix_off_q   <= pix_off_d;
            width_q     <= width_d;
            height_q    <= height_d;
            bpp_q       <= bpp_d;
            magic_ok_q  <= magic_ok_d;
            mode_q      <= mode_d;
            proc_q      <= proc_d;
            pack_q      <= pack_d;
            lane_q      <= lane_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            pad_q       <= pad_d;
            done_q      <= done_d;
            hdr_err_q   <= hdr_err_d;
        end
    end

    assign bus.byte_rdy       = (state_q == S_HDR) || (state_q == S_SKIP) ||
                                ((state_q == S_PIXEL) && !valid_q);
    assign bus.slv_data       = pack_q;
    assign bus.slv_data_valid = valid_q;
    assign slv_mode           = mode_q;
    assign slv_data_proc      = proc_q;
    assign pad_bytes          = pad_q;
    assign img_width          = width_q;
    assign img_height         = height_q;
    assign busy               = (state_q != S_IDLE);
    assign done               = done_q;
    assign hdr_err            = hdr_err_q;

endmodule
